cpu_load_sequencer: RTL

- Boot/run controller for the 16-bit simplified CPU.
- Accepts a host word stream over a valid/ready handshake and writes it into the CPU instruction and data stores through the CPU's unified load port (cpu_input, load_address, load, is_instruction).
- Releases the CPU from reset for a programmed number of cycles, then captures the CPU output_value as the run result.

---
 rtl/cpu_load_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_load_sequencer.sv
// Boot/run controller for the 16-bit CPU: streams host words into the instruction and
// data stores, releases the CPU from reset for a programmed cycle count, captures its output.
`timescale 1ns/1ps
module cpu_load_sequencer #(
  parameter int INSTR_DEPTH = 32,
  parameter int DATA_DEPTH  = 16,
  parameter int CYC_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [5:0]       instr_count_i,
  input  logic [4:0]       data_count_i,
  input  logic [CYC_W-1:0] run_cycles_i,
  input  logic [15:0]      host_data_i,
  input  logic             host_valid_i,
  output logic             host_ready_o,
  output logic [15:0]      cpu_input_o,
  output logic [4:0]       cpu_load_address_o,
  output logic             cpu_load_o,
  output logic             cpu_is_instruction_o,
  output logic             cpu_reset_o,
  input  logic [15:0]      cpu_output_value_i,
  output logic [15:0]      result_o,
  output logic             result_valid_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DONE} state_e;

  localparam logic [5:0] IMax = 6'(INSTR_DEPTH);
  localparam logic [4:0] DMax = 5'(DATA_DEPTH);

  state_e           state_q, state_d;
  logic [5:0]       iCount_q, iCount_d;
  logic [4:0]       dCount_q, dCount_d;
  logic [CYC_W-1:0] runCnt_q, runCnt_d;
  logic [5:0]       index_q, index_d;
  logic             hostReady_q, hostReady_d;
  logic [15:0]      cpuInput_q, cpuInput_d;
  logic [4:0]       cpuAddr_q, cpuAddr_d;
  logic             cpuLoad_q, cpuLoad_d;
  logic             cpuIsInstr_q, cpuIsInstr_d;
  logic             cpuReset_q, cpuReset_d;
  logic [15:0]      result_q, result_d;
  logic             resultValid_q, resultValid_d;
  logic             busy_q, busy_d;

  logic       transfer;
  logic       lastWord;
  logic [5:0] iClamp;
  logic [4:0] dClamp;

  assign iClamp   = (instr_count_i > IMax) ? IMax : instr_count_i;
  assign dClamp   = (data_count_i > DMax) ? DMax : data_count_i;
  assign transfer = hostReady_q & host_valid_i & ((state_q == LOAD_I) | (state_q == LOAD_D));
  assign lastWord = (state_q == LOAD_I) ? (index_q == iCount_q - 6'd1)
                                        : (index_q == {1'b0, dCount_q} - 6'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      iCount_q      <= '0;
      dCount_q      <= '0;
      runCnt_q      <= '0;
      index_q       <= '0;
      hostReady_q   <= 1'b0;
      cpuInput_q    <= '0;
      cpuAddr_q     <= '0;
      cpuLoad_q     <= 1'b0;
      cpuIsInstr_q  <= 1'b0;
      cpuReset_q    <= 1'b1;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      iCount_q      <= iCount_d;
      dCount_q      <= dCount_d;
      runCnt_q      <= runCnt_d;
      index_q       <= index_d;
      hostReady_q   <= hostReady_d;
      cpuInput_q    <= cpuInput_d;
      cpuAddr_q     <= cpuAddr_d;
      cpuLoad_q     <= cpuLoad_d;
      cpuIsInstr_q  <= cpuIsInstr_d;
      cpuReset_q    <= cpuReset_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      busy_q        <= busy_d;
    end
  end

  // RUN spends its first cycle with the CPU still in reset so the final load pulse
  // always lands before reset falls; the counter then gives run_cycles low cycles.
  always_comb begin
    state_d       = state_q;
    iCount_d      = iCount_q;
    dCount_d      = dCount_q;
    runCnt_d      = runCnt_q;
    index_d       = index_q;
    hostReady_d   = hostReady_q;
    cpuInput_d    = cpuInput_q;
    cpuAddr_d     = cpuAddr_q;
    cpuLoad_d     = 1'b0;
    cpuIsInstr_d  = cpuIsInstr_q;
    cpuReset_d    = cpuReset_q;
    result_d      = result_q;
    resultValid_d = resultValid_q;

    if (abort_i) begin
      state_d       = IDLE;
      hostReady_d   = 1'b0;
      cpuReset_d    = 1'b1;
      resultValid_d = 1'b0;
      index_d       = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            iCount_d      = iClamp;
            dCount_d      = dClamp;
            runCnt_d      = run_cycles_i;
            resultValid_d = 1'b0;
            index_d       = '0;
            cpuReset_d    = 1'b1;
            if (iClamp != 6'd0) begin
              state_d     = LOAD_I;
              hostReady_d = 1'b1;
            end else if (dClamp != 5'd0) begin
              state_d     = LOAD_D;
              hostReady_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        LOAD_I, LOAD_D: begin
          if (transfer) begin
            cpuLoad_d    = 1'b1;
            cpuInput_d   = host_data_i;
            cpuIsInstr_d = (state_q == LOAD_I);
            cpuAddr_d    = (state_q == LOAD_I) ? index_q[4:0] : {1'b0, index_q[3:0]};
            if (lastWord) begin
              index_d = '0;
              if ((state_q == LOAD_I) && (dCount_q != 5'd0)) begin
                state_d = LOAD_D;
              end else begin
                state_d     = RUN;
                hostReady_d = 1'b0;
              end
            end else begin
              index_d = index_q + 6'd1;
            end
          end
        end
        RUN: begin
          if (runCnt_q == '0) begin
            result_d      = cpu_output_value_i;
            resultValid_d = 1'b1;
            cpuReset_d    = 1'b1;
            state_d       = DONE;
          end else begin
            runCnt_d   = runCnt_q - CYC_W'(1);
            cpuReset_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LOAD_I) || (state_d == LOAD_D) || (state_d == RUN);
  end

  assign host_ready_o         = hostReady_q;
  assign cpu_input_o          = cpuInput_q;
  assign cpu_load_address_o   = cpuAddr_q;
  assign cpu_load_o           = cpuLoad_q;
  assign cpu_is_instruction_o = cpuIsInstr_q;
  assign cpu_reset_o          = cpuReset_q;
  assign result_o             = result_q;
  assign result_valid_o       = resultValid_q;
  assign busy_o               = busy_q;

endmodule
